// File: rtl/msb_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msb_sched_pkg
//  Description : Shared sizing constants and state encoding for the
//                highest-bit-first request scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package msb_sched_pkg;

    // Default request bitmap width and batch grant limit
    localparam int WIDTH      = 8;
    localparam int MAX_GRANTS = 3;
    localparam int POS_W      = $clog2(WIDTH);

    // Scheduler control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : msb_sched_pkg
`default_nettype wire

// File: rtl/msb_pos_enc.sv
`default_nettype none
// ============================================================================
//  Module      : msb_pos_enc
//  Description : Combinational highest-set-bit encoder. pos is the index of
//                the most significant set bit; valid flags a non-zero input.
//  Revision    : 1.0 - initial release
// ============================================================================
module msb_pos_enc #(
    parameter int WIDTH = msb_sched_pkg::WIDTH,
    parameter int POS_W = msb_sched_pkg::POS_W
) (
    input  logic [WIDTH-1:0] vec,
    output logic [POS_W-1:0] pos,
    output logic             valid
);

    // Scan upward so the highest set bit is the last one to win
    always_comb begin
        pos   = '0;
        valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                pos   = POS_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule : msb_pos_enc
`default_nettype wire

// File: rtl/msb_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : msb_req_scheduler
//  Description : Accepts a request bitmap and grants up to MAX_GRANTS of its
//                set bits, highest position first, over a valid/ready grant
//                channel. Ends each batch with a one-cycle batch_done pulse
//                reporting how many set bits were left ungranted.
//  Revision    : 1.0 - initial release
// ============================================================================
module msb_req_scheduler
    import msb_sched_pkg::state_t;
    import msb_sched_pkg::IDLE;
    import msb_sched_pkg::GRANT;
    import msb_sched_pkg::DONE;
#(
    parameter int WIDTH      = msb_sched_pkg::WIDTH,
    parameter int MAX_GRANTS = msb_sched_pkg::MAX_GRANTS,
    parameter int POS_W      = msb_sched_pkg::POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_vec,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [POS_W-1:0] gnt_pos,
    output logic             gnt_valid,
    input  logic             gnt_ready,
    output logic             gnt_last,
    input  logic             abort,
    output logic             batch_done,
    output logic [POS_W:0]   drop_cnt
);

    // Counters hold values up to WIDTH, so they need one bit beyond POS_W
    localparam int CNT_W = POS_W + 1;

    state_t             state, state_n;
    logic [WIDTH-1:0]   pending, pending_n;
    logic [CNT_W-1:0]   grant_cnt, grant_cnt_n;
    logic [CNT_W-1:0]   set_cnt, set_cnt_n;

    logic [POS_W-1:0]   enc_pos;
    logic               enc_valid;
    logic [CNT_W-1:0]   req_popcnt;
    logic               pend_single;
    logic [WIDTH-1:0]   gnt_mask;
    logic               gnt_fire;

    // Highest pending requester is the next one to be granted
    msb_pos_enc #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_pos_enc (
        .vec   (pending),
        .pos   (enc_pos),
        .valid (enc_valid)
    );

    // Number of set bits in the incoming request bitmap
    always_comb begin
        req_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            req_popcnt = req_popcnt + CNT_W'(req_vec[i]);
        end
    end

    // Pending-register helpers: single-bit test and one-hot mask of the grant
    always_comb begin
        pend_single       = enc_valid && ((pending & (pending - WIDTH'(1))) == '0);
        gnt_mask          = '0;
        gnt_mask[enc_pos] = 1'b1;
    end

    // Output decode from registered state only
    always_comb begin
        req_ready  = (state == IDLE);
        gnt_valid  = (state == GRANT) && enc_valid;
        gnt_pos    = gnt_valid ? enc_pos : '0;
        gnt_last   = gnt_valid &&
                     ((grant_cnt == CNT_W'(MAX_GRANTS - 1)) || pend_single);
        gnt_fire   = gnt_valid && gnt_ready;
        batch_done = (state == DONE);
        drop_cnt   = '0;
        if (state == DONE) begin
            // Saturate so the difference can never wrap below zero
            drop_cnt = (set_cnt >= grant_cnt) ? (set_cnt - grant_cnt) : '0;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_n     = state;
        pending_n   = pending;
        grant_cnt_n = grant_cnt;
        set_cnt_n   = set_cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    pending_n   = req_vec;
                    set_cnt_n   = req_popcnt;
                    grant_cnt_n = '0;
                    state_n     = (req_vec == '0) ? DONE : GRANT;
                end
            end
            GRANT: begin
                // A grant taken in the same cycle as abort still counts
                if (gnt_fire) begin
                    pending_n   = pending & ~gnt_mask;
                    grant_cnt_n = grant_cnt + CNT_W'(1);
                end
                if ((gnt_fire && gnt_last) || abort || !enc_valid) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            grant_cnt <= '0;
            set_cnt   <= '0;
        end else begin
            state     <= state_n;
            pending   <= pending_n;
            grant_cnt <= grant_cnt_n;
            set_cnt   <= set_cnt_n;
        end
    end

endmodule : msb_req_scheduler
`default_nettype wire

// File: tb/tb_msb_req_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msb_req_scheduler
//  Description : Self-checking bench for msb_req_scheduler. Vector table of
//                batches plus reset/abort sequences; expected grants come
//                from a bench-side model through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msb_req_scheduler;

    localparam int WIDTH      = 8;
    localparam int MAX_GRANTS = 3;
    localparam int POS_W      = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] req_vec;
    logic             req_valid;
    logic             req_ready;
    logic [POS_W-1:0] gnt_pos;
    logic             gnt_valid;
    logic             gnt_ready;
    logic             gnt_last;
    logic             abort;
    logic             batch_done;
    logic [POS_W:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] vec;
        int               stall;
        int               abort_after;
        int               exp_drop;
    } vec_t;

    typedef struct {
        logic [POS_W-1:0] pos;
        logic             last;
    } gnt_t;

    gnt_t gq[$];
    vec_t tbl[8];

    msb_req_scheduler #(
        .WIDTH      (WIDTH),
        .MAX_GRANTS (MAX_GRANTS),
        .POS_W      (POS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vec    (req_vec),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .gnt_pos    (gnt_pos),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .gnt_last   (gnt_last),
        .abort      (abort),
        .batch_done (batch_done),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int popcnt(input logic [WIDTH-1:0] v);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
        return n;
    endfunction

    // Reference model: descending positions, at most MAX_GRANTS, truncated by abort
    task automatic push_model(input logic [WIDTH-1:0] v, input int abort_after,
                              output int n_push);
        int   rem;
        int   n;
        gnt_t g;
        rem    = popcnt(v);
        n      = 0;
        n_push = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i] && n < MAX_GRANTS) begin
                g.pos  = POS_W'(i);
                g.last = (n == MAX_GRANTS - 1) || (rem == 1);
                if (abort_after < 0 || n < abort_after) begin
                    gq.push_back(g);
                    n_push++;
                end
                n++;
                rem--;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  int'(req_ready),  1);
        chk({tag, "_gnt_valid"},  int'(gnt_valid),  0);
        chk({tag, "_gnt_pos"},    int'(gnt_pos),    0);
        chk({tag, "_gnt_last"},   int'(gnt_last),   0);
        chk({tag, "_batch_done"}, int'(batch_done), 0);
        chk({tag, "_drop_cnt"},   int'(drop_cnt),   0);
    endtask

    // Drive one batch and check every grant and the closing pulse
    task automatic run_batch(input logic [WIDTH-1:0] v, input int stall,
                             input int abort_after, input int exp_drop);
        int   n_exp;
        int   accepted   = 0;
        int   cycles     = 0;
        int   stall_left = stall;
        int   first_cnt  = 0;
        bit   done_seen  = 0;
        bit   abort_sent = 0;
        gnt_t g;
        gq.delete();
        push_model(v, abort_after, n_exp);
        @(negedge clk);
        chk("req_ready_idle", int'(req_ready), 1);
        req_vec   = v;
        req_valid = 1'b1;
        gnt_ready = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_vec   = '0;
        if (v != '0) chk("latency_gnt_valid", int'(gnt_valid), 1);
        else         chk("latency_zero_done", int'(batch_done), 1);
        while (!done_seen && cycles < 60) begin
            abort     = 1'b0;
            gnt_ready = 1'b0;
            if (batch_done) begin
                chk("drop_cnt_table", int'(drop_cnt), exp_drop);
                chk("drop_cnt_model", int'(drop_cnt), popcnt(v) - accepted);
                chk("gnt_valid_in_done", int'(gnt_valid), 0);
                chk("grants_accepted", accepted, n_exp);
                done_seen = 1;
            end else if (gnt_valid) begin
                if (abort_sent) begin
                    chk("no_grant_after_abort", int'(gnt_valid), 0);
                end else if (abort_after >= 0 && accepted >= abort_after) begin
                    abort      = 1'b1;
                    abort_sent = 1;
                end else if (gq.size() == 0) begin
                    chk("extra_grant", int'(gnt_valid), 0);
                end else begin
                    g = gq[0];
                    chk("gnt_pos", int'(gnt_pos), int'(g.pos));
                    chk("gnt_last", int'(gnt_last), int'(g.last));
                    if (accepted == 0) first_cnt++;
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        gnt_ready = 1'b1;
                        void'(gq.pop_front());
                        accepted++;
                    end
                end
            end else begin
                chk("busy_no_output", int'(gnt_valid), 1);
            end
            @(negedge clk);
            cycles++;
        end
        abort     = 1'b0;
        gnt_ready = 1'b0;
        if (!done_seen) chk("batch_timeout", int'(done_seen), 1);
        if (v != '0 && abort_after != 0) chk("first_grant_hold", first_cnt, stall + 1);
        chk("done_single_cycle", int'(batch_done), 0);
        chk("ready_after_done", int'(req_ready), 1);
    endtask

    initial begin
        logic [WIDTH-1:0] rv;
        int               pc;
        rst       = 1'b1;
        req_vec   = '0;
        req_valid = 1'b0;
        gnt_ready = 1'b0;
        abort     = 1'b0;

        tbl[0] = '{8'b1001_0010, 0, -1, 0};
        tbl[1] = '{8'b1111_1111, 0, -1, 5};
        tbl[2] = '{8'b0000_1010, 3, -1, 0};
        tbl[3] = '{8'b0000_0000, 0, -1, 0};
        tbl[4] = '{8'b0011_1000, 0,  1, 2};
        tbl[5] = '{8'b1000_0000, 1, -1, 0};
        tbl[6] = '{8'b0000_0111, 0, -1, 0};
        tbl[7] = '{8'b0101_0101, 2, -1, 1};

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst_init");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_rst");

        for (int i = 0; i < 8; i++) begin
            run_batch(tbl[i].vec, tbl[i].stall, tbl[i].abort_after, tbl[i].exp_drop);
        end

        // abort while idle is ignored
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_ready", int'(req_ready), 1);
        chk("idle_abort_done", int'(batch_done), 0);
        chk("idle_abort_valid", int'(gnt_valid), 0);
        abort = 1'b0;

        // reset in the middle of a batch
        @(negedge clk);
        req_vec   = 8'b1001_0010;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_vec   = '0;
        chk("mid_rst_first_pos", int'(gnt_pos), 7);
        gnt_ready = 1'b1;
        @(negedge clk);
        gnt_ready = 1'b0;
        chk("mid_rst_second_pos", int'(gnt_pos), 4);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_no_done", int'(batch_done), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_no_done", int'(batch_done), 0);
        run_batch(8'b0000_1000, 0, -1, 0);

        // randomised batches checked against the model
        for (int r = 0; r < 6; r++) begin
            rv = WIDTH'($urandom);
            pc = popcnt(rv);
            run_batch(rv, $urandom_range(0, 2), -1,
                      (pc > MAX_GRANTS) ? (pc - MAX_GRANTS) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_msb_req_scheduler
`default_nettype wire

// File: doc/msb_req_scheduler.md
MSB_REQ_SCHEDULER -- requirements
Module: msb_req_scheduler

Interface
REQ-001 Parameter WIDTH, default 8: width of the request bitmap.
REQ-002 Parameter MAX_GRANTS, default 3: maximum grants issued per batch.
REQ-003 Parameter POS_W, default 3: width of a bit-position index, equal to clog2(WIDTH).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_vec  in  WIDTH  request bitmap; bit i set means requester i is pending.
REQ-008 req_valid  in  1  req_vec is valid.
REQ-009 req_ready  out  1  scheduler can accept a new batch; high only in IDLE.
REQ-010 gnt_pos  out  POS_W  position of the currently granted requester.
REQ-011 gnt_valid  out  1  gnt_pos is valid.
REQ-012 gnt_ready  in  1  consumer accepts gnt_pos.
REQ-013 gnt_last  out  1  qualifies gnt_valid; marks the final grant of the batch.
REQ-014 abort  in  1  terminates the current batch.
REQ-015 batch_done  out  1  one-cycle pulse marking the end of a batch.
REQ-016 drop_cnt  out  POS_W+1  number of set bits not granted; valid with batch_done.

Function
REQ-017 The block SHALL implement the states IDLE, GRANT and DONE.
REQ-018 In IDLE, a handshake (req_valid && req_ready) SHALL latch req_vec into the pending register, load popcount(req_vec) into a set-bit counter, clear the grant count, and move to GRANT.
REQ-019 A zero req_vec SHALL move to DONE, with no grants issued and drop_cnt=0.
REQ-020 In GRANT, gnt_valid SHALL be 1 and gnt_pos SHALL be the highest set bit of the pending register.
REQ-021 Latency SHALL be one cycle: handshake at edge N gives gnt_valid high in the cycle after edge N.
REQ-022 gnt_pos and gnt_last SHALL be held stable while gnt_valid && !gnt_ready.
REQ-023 On each gnt_valid && gnt_ready, the block SHALL clear the granted bit in the pending register and increment the grant count.
REQ-024 gnt_last SHALL be 1 when grant count == MAX_GRANTS-1 or the pending register has exactly one bit set.
REQ-025 Acceptance of a grant with gnt_last=1 SHALL move to DONE.
REQ-026 Grants SHALL be issued in strictly descending position order.
REQ-027 Set bits below the MAX_GRANTS highest SHALL never be granted.
REQ-028 DONE SHALL last exactly one cycle with batch_done=1 and drop_cnt = popcount - grants accepted, then return to IDLE.
REQ-029 abort in GRANT SHALL move to DONE with no further grants; a grant accepted in the same cycle as abort counts as issued.
REQ-030 abort in IDLE or DONE SHALL be ignored.
REQ-031 req_valid outside IDLE SHALL be ignored; no queuing.
REQ-032 Grant count and drop_cnt arithmetic SHALL be unsigned, and drop_cnt SHALL never underflow.

Reset
REQ-033 rst SHALL asynchronously force state=IDLE and clear the pending register, grant count and set-bit counter.
REQ-034 During and after reset, the outputs SHALL be: req_ready=1, gnt_valid=0, gnt_pos=0, gnt_last=0, batch_done=0, drop_cnt=0.
REQ-035 Reset mid-batch SHALL discard the batch without issuing a batch_done pulse.

Structure
REQ-036 Package msb_sched_pkg SHALL hold WIDTH, MAX_GRANTS, POS_W and the state enum (IDLE, GRANT, DONE).
REQ-037 Sub-module msb_pos_enc SHALL be a combinational highest-set-bit encoder of WIDTH bits with outputs pos and valid, instantiated once on the pending register.
REQ-038 Registered state SHALL be limited to state, the pending register, the grant count and the set-bit counter; all outputs other than drop_cnt SHALL be decoded from these.

Verification
REQ-039 req_vec=1001_0010, gnt_ready=1 -> gnt_pos 7,4,1; last on 1; batch_done with drop_cnt=0.
REQ-040 req_vec=1111_1111 -> gnt_pos 7,6,5; last on 5; drop_cnt=5.
REQ-041 req_vec=0000_1010, with gnt_ready low for 3 cycles on the first grant -> gnt_pos held at 3 for 4 cycles, then 1 with last=1; drop_cnt=0.
REQ-042 req_vec=0000_0000 -> no gnt_valid; batch_done in the cycle after the handshake; req_ready=1 the following cycle.
REQ-043 req_vec=0011_1000, abort after the first grant (5) -> no grant 4; batch_done with drop_cnt=2.
REQ-044 req_vec=1001_0010, rst asserted after the first grant -> outputs at reset values immediately; no batch_done; the next batch 0000_1000 grants 3 with last=1.
